muldiv_16b: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit in the execute stage of the pipelined processor.
- Its 16-bit result is one data input of the 8:1 writeback/result-select mux.
- Uses a start/busy/done handshake; the hazard logic stalls the pipeline while busy=1.
- One bit is computed per clock: shift-add for multiply, restoring division for divide.

---
 rtl/muldiv_16b_pkg.sv | 37 +++
 rtl/muldiv_step_16b.sv | 44 ++++
 rtl/muldiv_16b.sv | 108 ++++++++++
 tb/tb_muldiv_16b.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_16b_pkg.sv
// Shared encodings and helpers for the iterative 16-bit multiply/divide unit.
// Imported by the top level and by the single-iteration datapath.
package muldiv_16b_pkg;

    localparam int DATA_W = 16;
    localparam int ITERS  = 16;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    function automatic logic is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Accumulator layout: MUL = {product_hi, product_lo}, DIV = {remainder, quotient}
    function automatic logic [DATA_W-1:0] select_result(input op_e op,
                                                        input logic [2*DATA_W-1:0] acc);
        return ((op == OP_MULLO) || (op == OP_DIVU)) ? acc[DATA_W-1:0]
                                                     : acc[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/muldiv_step_16b.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// Returns the next upper partial value and, for divide, the new quotient bit.
module muldiv_step_16b
    import muldiv_16b_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] partial,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   next_partial,
    output logic             q_bit
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = operand[gi] & in_bit;
        end
    endgenerate

    assign shifted = {partial, in_bit};
    assign diff    = {1'b0, shifted} - {2'b00, operand};

    always_comb begin
        next_partial = '0;
        q_bit        = 1'b0;
        if (mode == MODE_MUL) begin
            next_partial = {1'b0, partial} + {1'b0, addend};
        end else if (diff[WIDTH+1]) begin
            // Borrow: restore the shifted remainder
            next_partial = shifted;
        end else begin
            next_partial = diff[WIDTH:0];
            q_bit        = 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_16b.sv
// Iterative unsigned 16-bit MUL/DIVU/REMU unit, one bit per clock, with
// start/busy/done handshake, flush abort and back-to-back issue from DONE.
module muldiv_16b
    import muldiv_16b_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    state_e             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand_reg;
    op_e                op_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               dbz_reg;

    logic               mode;
    logic               in_bit;
    logic [WIDTH:0]     step_partial;
    logic               step_q;
    logic               accept;
    logic               last_iter;

    assign mode   = is_div(op_reg) ? MODE_DIV : MODE_MUL;
    // Multiply consumes multiplier bits LSB-first, divide consumes dividend bits MSB-first
    assign in_bit = (mode == MODE_DIV) ? acc_reg[WIDTH-1] : acc_reg[0];

    muldiv_step_16b #(.WIDTH(WIDTH)) u_step (
        .mode         (mode),
        .partial      (acc_reg[2*WIDTH-1:WIDTH]),
        .in_bit       (in_bit),
        .operand      (operand_reg),
        .next_partial (step_partial),
        .q_bit        (step_q)
    );

    always_comb begin
        acc_next = acc_reg;
        if (mode == MODE_DIV)
            acc_next = {step_partial[WIDTH-1:0], acc_reg[WIDTH-2:0], step_q};
        else
            acc_next = {step_partial, acc_reg[WIDTH-1:1]};
    end

    assign accept    = start && !flush && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_iter = (cnt_reg == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            operand_reg <= '0;
            op_reg      <= OP_MULLO;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                state_reg   <= ST_RUN;
                cnt_reg     <= '0;
                op_reg      <= op_e'(op);
                acc_reg     <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
                operand_reg <= op[1] ? b : a;
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        if (flush) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            acc_reg <= acc_next;
                            cnt_reg <= cnt_reg + 1'b1;
                            if (last_iter) begin
                                state_reg  <= ST_DONE;
                                done_reg   <= 1'b1;
                                result_reg <= select_result(op_reg, acc_next);
                                dbz_reg    <= is_div(op_reg) && (operand_reg == '0);
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = (state_reg == ST_RUN);
    assign done        = done_reg;
    assign result      = result_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_muldiv_16b.sv
// Self-checking bench for muldiv_16b: directed and random operations checked
// against a plain-arithmetic reference, plus flush/reset/handshake corner cases.
module tb_muldiv_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    muldiv_16b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {div_by_zero, result} from plain arithmetic
    function automatic logic [16:0] ref_model(input logic [1:0] o, input logic [15:0] x,
                                              input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0, x} * {16'h0, y};
        case (o)
            2'd0:    return {1'b0, p[15:0]};
            2'd1:    return {1'b0, p[31:16]};
            2'd2:    return (y == 16'h0) ? {1'b1, 16'hFFFF} : {1'b0, x / y};
            default: return (y == 16'h0) ? {1'b1, x} : {1'b0, x % y};
        endcase
    endfunction

    // Issues one op and waits (bounded) for done; lat counts edges after the accepting edge
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output logic z, output int lat,
                          output int busy_n);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = int'(busy);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            busy_n += int'(busy);
            if (done) break;
        end
        r = result;
        z = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h want=0000", result); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [12] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [15:0] as  [12] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0,
                                  16'd100, 16'd100, 16'd5, 16'd5, 16'h1234, 16'h1234};
        logic [15:0] bs  [12] = '{16'h0010, 16'h0010, 16'hFFFF, 16'hFFFF, 16'hBEEF, 16'hBEEF,
                                  16'd7, 16'd7, 16'd9, 16'd9, 16'h0, 16'h0};
        logic [15:0] exp_r [12] = '{16'h2340, 16'h0001, 16'h0001, 16'hFFFE, 16'h0, 16'h0,
                                    16'h000E, 16'h0002, 16'h0, 16'h5, 16'hFFFF, 16'h1234};
        logic        exp_z [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [15:0] r;
        logic        z;
        int          lat, bn;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], r, z, lat, bn);
            $display("directed op=%0d a=%h b=%h -> result=%h dbz=%b lat=%0d busy=%0d",
                     ops[i], as[i], bs[i], r, z, lat, bn);
            checks++; if (r !== exp_r[i]) begin errors++; $display("FAIL dir_result[%0d] got=%h want=%h", i, r, exp_r[i]); end
            checks++; if (z !== exp_z[i]) begin errors++; $display("FAIL dir_dbz[%0d] got=%b want=%b", i, z, exp_z[i]); end
            checks++; if (lat != 16) begin errors++; $display("FAIL dir_latency[%0d] got=%0d want=16", i, lat); end
            checks++; if (bn != 16) begin errors++; $display("FAIL dir_busy_cycles[%0d] got=%0d want=16", i, bn); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [15:0] x, y, r;
        logic        z;
        logic [16:0] e;
        int          lat, bn;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       y = 16'h0;
                1:       y = 16'($urandom_range(1, 15));
                default: y = 16'($urandom);
            endcase
            e = ref_model(o, x, y);
            run_op(o, x, y, r, z, lat, bn);
            $display("random op=%0d a=%h b=%h -> result=%h dbz=%b expect=%h/%b lat=%0d",
                     o, x, y, r, z, e[15:0], e[16], lat);
            checks++; if (r !== e[15:0]) begin errors++; $display("FAIL rnd_result[%0d] got=%h want=%h", i, r, e[15:0]); end
            checks++; if (z !== e[16]) begin errors++; $display("FAIL rnd_dbz[%0d] got=%b want=%b", i, z, e[16]); end
            checks++; if (lat != 16) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d want=16", i, lat); end
        end
    endtask

    task automatic test_flush();
        logic [15:0] r;
        logic        z, saw;
        int          lat, bn;
        run_op(2'd0, 16'd3, 16'd5, r, z, lat, bn);
        @(negedge clk);
        op = 2'd2; a = 16'd1000; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush after 5 cycles -> busy=%b done=%b result=%h", busy, done, result);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if (result !== 16'd15) begin errors++; $display("FAIL flush_result got=%h want=000f", result); end
        saw = done;
        repeat (25) begin @(posedge clk); #1; saw |= done; end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b want=0", saw); end
        checks++; if (result !== 16'd15) begin errors++; $display("FAIL flush_result_hold got=%h want=000f", result); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] r;
        logic        z;
        logic [16:0] e;
        int          lat, bn;
        @(negedge clk);
        op = 2'd1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-run -> busy=%b done=%b result=%h dbz=%b", busy, done, result, div_by_zero);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL rst_mid_result got=%h want=0000", result); end
        checks++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got=%b%b want=00", done, div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        e = ref_model(2'd3, 16'd1000, 16'd7);
        run_op(2'd3, 16'd1000, 16'd7, r, z, lat, bn);
        $display("post-reset op=3 a=1000 b=7 -> result=%h lat=%0d", r, lat);
        checks++; if (r !== e[15:0] || lat != 16) begin
            errors++; $display("FAIL rst_recover got=%h/%0d want=%h/16", r, lat, e[15:0]); end
    endtask

    task automatic test_start_during_run();
        logic [16:0] e;
        int          lat;
        e = ref_model(2'd0, 16'd300, 16'd200);
        @(negedge clk);
        op = 2'd0; a = 16'd300; b = 16'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin op = 2'd3; a = 16'd9; b = 16'd4; start = 1'b1; end
            if (lat == 10) start = 1'b0;
            if (done) break;
        end
        $display("start during run -> result=%h lat=%0d", result, lat);
        checks++; if (result !== e[15:0]) begin errors++; $display("FAIL run_ignore_result got=%h want=%h", result, e[15:0]); end
        checks++; if (lat != 16) begin errors++; $display("FAIL run_ignore_latency got=%0d want=16", lat); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_ignore_idle got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        logic        z;
        logic [16:0] e1, e2;
        int          lat, bn, n;
        e1 = ref_model(2'd2, 16'd5000, 16'd3);
        e2 = ref_model(2'd1, 16'hABCD, 16'h1234);
        run_op(2'd2, 16'd5000, 16'd3, r, z, lat, bn);
        checks++; if (r !== e1[15:0]) begin errors++; $display("FAIL b2b_first got=%h want=%h", r, e1[15:0]); end
        op = 2'd1; a = 16'hABCD; b = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept got=busy%b/done%b want=busy1/done0", busy, done); end
        n = 1;
        while (n < 45) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        $display("back-to-back second op -> result=%h gap=%0d", result, n);
        checks++; if (n != 17) begin errors++; $display("FAIL b2b_gap got=%0d want=17", n); end
        checks++; if (result !== e2[15:0]) begin errors++; $display("FAIL b2b_second got=%h want=%h", result, e2[15:0]); end
    endtask

    task automatic test_flush_start_done();
        logic [15:0] r;
        logic        z, saw;
        int          lat, bn;
        run_op(2'd0, 16'd7, 16'd9, r, z, lat, bn);
        op = 2'd2; a = 16'd50; b = 16'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        $display("flush+start in DONE -> busy=%b done=%b result=%h", busy, done, result);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL fs_idle got=busy%b/done%b want=busy0/done0", busy, done); end
        saw = 1'b0;
        repeat (25) begin @(posedge clk); #1; saw |= done | busy; end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL fs_nothing_issued got=%b want=0", saw); end
        checks++; if (result !== 16'd63) begin errors++; $display("FAIL fs_result got=%h want=003f", result); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid_run();
        test_start_during_run();
        test_back_to_back();
        test_flush_start_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
